// File: rtl/mux8way_pkg.sv
// Shared constants, register-state encoding and select helper for the 8-way channel fabric.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux8way_pkg;

    localparam int N_CH      = 8;
    localparam int SEL_W     = 3;
    localparam int DEF_WIDTH = 16;

    // Output register occupancy: EMPTY means out/z are stale, FULL means they hold a word.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Decode a channel index into its one-hot ready/select vector.
    function automatic logic [N_CH-1:0] onehot8(input logic [SEL_W-1:0] sel);
        onehot8 = 8'b0000_0001 << sel;
    endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// 8-requester arbiter: circular search from last+1 (round-robin), or from 0 when fixed=1.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: none inside; the caller qualifies the grant with its own load enable.
module rr_arbiter8
    import mux8way_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    input  logic             fixed,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down to the nearest so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        start   = fixed ? '0 : last + 3'd1;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = start + 3'(k);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8way_rr.sv
// Merges eight valid/ready channels into one registered stream tagged with its source index z.
// Latency: 1 clk from accept (in_ready) to out_valid; full throughput while out_ready=1.
// Backpressure: while FULL and out_ready=0 every in_ready is 0 and out/z/last hold.
module mux8way_rr
    import mux8way_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FIXED_PRI = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [7:0]       in_valid,
    output logic [7:0]       in_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    out_state_t       state;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] in_arr [N_CH];
    logic [WIDTH-1:0] sel_dat;

    rr_arbiter8 u_arb (
        .req     (in_valid),
        .last    (last),
        .fixed   (FIXED_PRI != 0),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;
    assign in_arr[4] = in4;
    assign in_arr[5] = in5;
    assign in_arr[6] = in6;
    assign in_arr[7] = in7;
    assign sel_dat   = in_arr[gnt_idx];

    // The register can take a word when empty or when its current word leaves this cycle.
    // rst_n gates the accept so nothing is handshaken while reset is held.
    assign can_load  = (state == ST_EMPTY) || out_ready;
    assign load      = rst_n && can_load && gnt_any;
    assign in_ready  = load ? onehot8(gnt_idx) : 8'h00;
    assign out_valid = (state == ST_FULL);
    assign busy      = out_valid || (|in_valid);

    // Output register and round-robin pointer; a load overrides a simultaneous drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            out   <= '0;
            z     <= '0;
            last  <= 3'b111;
        end else if (load) begin
            state <= ST_FULL;
            out   <= sel_dat;
            z     <= gnt_idx;
            last  <= gnt_idx;
        end else if (out_ready && state == ST_FULL) begin
            state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_mux8way_rr.sv
// Directed table-driven bench for mux8way_rr, plus loopback and mid-stream reset sequences.
// Latency: checks in_ready 1 ns after driving, registered outputs 1 ns after the rising edge.
// Backpressure: exercised by table rows holding out_ready low.
module tb_mux8way_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din [8];
    logic [7:0]  in_valid;
    logic        out_ready;
    logic [7:0]  in_ready,  fp_in_ready;
    logic [15:0] out,       fp_out;
    logic [2:0]  z,         fp_z;
    logic        out_valid, fp_out_valid;
    logic        busy,      fp_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] base;
        logic [7:0]  vld;
        logic        ordy;
        logic [7:0]  rdy;
        logic        ov;
        logic [2:0]  ez;
        logic [15:0] dout;
        logic        chk_fp;
    } vec_t;

    vec_t vecs[$];
    int   rx_cnt [8];

    always #5 clk = ~clk;

    mux8way_rr #(.WIDTH(16), .FIXED_PRI(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
        .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .z(z), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    mux8way_rr #(.WIDTH(16), .FIXED_PRI(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
        .in_valid(in_valid), .in_ready(fp_in_ready),
        .out(fp_out), .z(fp_z), .out_valid(fp_out_valid), .out_ready(out_ready), .busy(fp_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] base, input logic [7:0] vld, input logic ordy);
        for (int k = 0; k < 8; k++) din[k] = base ^ 16'(k);
        in_valid  = vld;
        out_ready = ordy;
    endtask

    task automatic add(input logic [15:0] b, input logic [7:0] v, input logic r,
                       input logic [7:0] rdy, input logic ov, input logic [2:0] ez,
                       input logic [15:0] d, input logic cf);
        vec_t t;
        t.base = b; t.vld = v; t.ordy = r; t.rdy = rdy;
        t.ov = ov; t.ez = ez; t.dout = d; t.chk_fp = cf;
        vecs.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Round-robin from reset: 0..7 then 0 again, one word per clock.
        add(16'h0000, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 16'h0000, 1'b1);
        add(16'h0000, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 16'h0001, 1'b0);
        add(16'h0000, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 16'h0002, 1'b0);
        add(16'h0000, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 16'h0003, 1'b0);
        add(16'h0000, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 16'h0004, 1'b0);
        add(16'h0000, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 16'h0005, 1'b0);
        add(16'h0000, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6, 16'h0006, 1'b0);
        add(16'h0000, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 16'h0007, 1'b0);
        add(16'h0000, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 16'h0000, 1'b0);
        // Single channel 3 carrying F0F0, then a drain that keeps out/z.
        add(16'hF0F3, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 16'hF0F0, 1'b0);
        add(16'hF0F3, 8'h00, 1'b1, 8'h00, 1'b0, 3'd3, 16'hF0F0, 1'b0);
        // Load ch2 (search from 4 wraps round), then hold off for 5 clocks.
        add(16'h0000, 8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 16'h0002, 1'b0);
        for (int i = 0; i < 5; i++)
            add(16'h0000, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd2, 16'h0002, 1'b0);
        add(16'h0000, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 16'h0003, 1'b0);
        // last=6, then only ch0/ch1 requesting: 0,1,0; fixed priority stays on 0.
        add(16'h0000, 8'h40, 1'b1, 8'h40, 1'b1, 3'd6, 16'h0006, 1'b0);
        add(16'h0000, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 16'h0000, 1'b1);
        add(16'h0000, 8'h03, 1'b1, 8'h02, 1'b1, 3'd1, 16'h0001, 1'b1);
        add(16'h0000, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0, 16'h0000, 1'b1);
        // Grant to 7 wraps the pointer so channel 0 is next.
        add(16'h0000, 8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 16'h0007, 1'b0);
        add(16'h0000, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 16'h0000, 1'b0);
        add(16'h0000, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0);

        // Reset held with every channel requesting.
        rst_n = 1'b0;
        drive(16'h0000, 8'hFF, 1'b1);
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z",         32'(z),         32'd0);
        check("rst_out",       32'(out),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        in_valid = 8'h00;
        rst_n    = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].base, vecs[i].vld, vecs[i].ordy);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            @(posedge clk); #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            check($sformatf("v%0d_z", i),         32'(z),         32'(vecs[i].ez));
            check($sformatf("v%0d_out", i),       32'(out),       32'(vecs[i].dout));
            if (vecs[i].chk_fp)
                check($sformatf("v%0d_fixed_z", i), 32'(fp_z), 32'd0);
        end

        // busy follows out_valid | any in_valid.
        @(negedge clk);
        drive(16'h0000, 8'h00, 1'b1);
        #1 check("busy_idle", 32'(busy), 32'd0);
        in_valid = 8'h01;
        #1 check("busy_req", 32'(busy), 32'd1);

        // Loopback through a modelled demux: every word must land on its own channel.
        @(negedge clk);
        drive(16'hF0F0, 8'hFF, 1'b1);
        for (int k = 0; k < 8; k++) rx_cnt[k] = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            check("loop_out_valid", 32'(out_valid), 32'd1);
            check("loop_data", 32'(out), 32'(16'hF0F0 ^ {13'd0, z}));
            rx_cnt[z]++;
        end
        for (int k = 0; k < 8; k++)
            check($sformatf("loop_cnt%0d", k), 32'(rx_cnt[k]), 32'd2);

        // Reset mid-stream: out_valid must drop without waiting for an edge.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_z",         32'(z),         32'd0);
        @(negedge clk);
        in_valid = 8'h00;
        rst_n    = 1'b1;
        @(negedge clk);
        in_valid = 8'hFF;
        #1 check("postrst_in_ready", 32'(in_ready), 32'h01);
        @(posedge clk); #1;
        check("postrst_z",   32'(z),   32'd0);
        check("postrst_out", 32'(out), 32'hF0F0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
